// File: rtl/rx_iq_packer_if.sv
// Sample input strobe and byte output stream of the receiver I/Q packer.
// The master drives samples and out_ready; the slave (the packer) drives the byte stream.
interface rx_iq_packer_if;
  logic               in_strobe;
  logic signed [23:0] in_I;
  logic signed [23:0] in_Q;
  logic        [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic               out_eof;

  modport master (
    output in_strobe, in_I, in_Q, out_ready,
    input  out_data, out_valid, out_sof, out_eof
  );

  modport slave (
    input  in_strobe, in_I, in_Q, out_ready,
    output out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/rx_iq_packer.sv
// Buffers strobed 24-bit I/Q samples in a FIFO and serialises each one as six bytes
// (I then Q, MSB first) on a valid/ready stream with frame start/end markers.
module rx_iq_packer #(
  parameter int DEPTH             = 16,
  parameter int SAMPLES_PER_FRAME = 63
) (
  input  logic                    clock,
  input  logic                    rst_n,
  rx_iq_packer_if.slave           io,
  input  logic                    clear_overflow,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_SMP = CW'(SAMPLES_PER_FRAME - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [47:0]   mem_q [DEPTH];
  logic [47:0]   shreg_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          ovf_q;

  logic          empty, full, push, pop, drop, valid;
  logic [7:0]    byte_sel;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        if (io.out_ready) begin
          if (idx_q == 3'd5) begin
            cnt_d = (cnt_q == LAST_SMP) ? '0 : cnt_q + CW'(1);
            idx_d = 3'd0;
            // Back-to-back samples reload without an idle cycle.
            if (!empty) pop = 1'b1;
            else        state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a sample when a slot frees in the same cycle.
  assign push = io.in_strobe && (!full || pop);
  assign drop = io.in_strobe && !push;

  always_comb begin
    case (idx_q)
      3'd0:    byte_sel = shreg_q[47:40];
      3'd1:    byte_sel = shreg_q[39:32];
      3'd2:    byte_sel = shreg_q[31:24];
      3'd3:    byte_sel = shreg_q[23:16];
      3'd4:    byte_sel = shreg_q[15:8];
      default: byte_sel = shreg_q[7:0];
    endcase
  end

  assign io.out_valid = valid;
  assign io.out_data  = valid ? byte_sel : 8'd0;
  assign io.out_sof   = valid && (idx_q == 3'd0) && (cnt_q == '0);
  assign io.out_eof   = valid && (idx_q == 3'd5) && (cnt_q == LAST_SMP);
  assign overflow     = ovf_q;
  assign fill_level   = count_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)                ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

  // Sample storage carries no reset; pointers and state alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {io.in_I, io.in_Q};
    if (pop)  shreg_q         <= mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_rx_iq_packer.sv
// Directed bench for rx_iq_packer: expected bytes are queued when samples are driven
// and checked, with frame markers, as the byte stream hands them over.
module tb_rx_iq_packer;
  localparam int DEPTH = 16;
  localparam int SPF   = 63;
  localparam int FB    = 6 * SPF;

  logic                   clock = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear_overflow = 1'b0;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fill_level;

  rx_iq_packer_if bus();

  rx_iq_packer #(.DEPTH(DEPTH), .SAMPLES_PER_FRAME(SPF)) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .io             (bus),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .fill_level     (fill_level)
  );

  always #5 clock = ~clock;

  int         tests, fails;
  logic [7:0] q[$];
  int         mbyte, dcount, eof_pos, sof2_pos, idle_cnt;
  bit         track;
  logic       prev_stall;
  logic [9:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [23:0] iv, input logic [23:0] qv, input bit accept);
    bus.in_I      = iv;
    bus.in_Q      = qv;
    bus.in_strobe = 1'b1;
    if (accept) begin
      q.push_back(iv[23:16]); q.push_back(iv[15:8]); q.push_back(iv[7:0]);
      q.push_back(qv[23:16]); q.push_back(qv[15:8]); q.push_back(qv[7:0]);
    end
    tick();
    bus.in_strobe = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    bus.out_ready = 1'b1;
    for (int k = 0; k < bound && (q.size() != 0 || bus.out_valid); k++) tick();
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_idle"}, bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    mbyte = 0; dcount = 0; eof_pos = 0; sof2_pos = 0; idle_cnt = 0;
  endtask

  initial begin
    logic [23:0] ri, rq;
    tests = 0; fails = 0; mbyte = 0; dcount = 0; eof_pos = 0; sof2_pos = 0;
    idle_cnt = 0; track = 1'b0; prev_stall = 1'b0; prev_out = '0;
    bus.in_strobe = 1'b0; bus.in_I = '0; bus.in_Q = '0; bus.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (!rst_n) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_bus", {bus.out_sof, bus.out_eof, bus.out_data}, prev_out);
          end
          if (track && !bus.out_valid && dcount > 0 && dcount < 64 * 6) idle_cnt++;
          if (bus.out_valid && bus.out_ready) begin
            dcount++;
            chk("extra_byte", q.size() == 0, 1'b0);
            if (q.size() > 0) chk("data", bus.out_data, q.pop_front());
            chk("sof", bus.out_sof, mbyte == 0);
            chk("eof", bus.out_eof, mbyte == FB - 1);
            if (bus.out_eof && eof_pos == 0) eof_pos = dcount;
            if (bus.out_sof && dcount > 1 && sof2_pos == 0) sof2_pos = dcount;
            mbyte = (mbyte == FB - 1) ? 0 : mbyte + 1;
          end
          prev_stall = bus.out_valid && !bus.out_ready;
          prev_out   = {bus.out_sof, bus.out_eof, bus.out_data};
        end
      end
    join_none

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_sof", bus.out_sof, 1'b0);
    chk("rst_eof", bus.out_eof, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_fill", fill_level, 0);

    // Single sample, latency and byte order
    strobe(24'h123456, 24'hABCDEF, 1'b1);
    chk("t1_fill", fill_level, 1);
    chk("t1_lat1", bus.out_valid, 1'b0);
    tick();
    chk("t1_lat2", bus.out_valid, 1'b1);
    chk("t1_b0", bus.out_data, 8'h12);
    chk("t1_sof", bus.out_sof, 1'b1);
    chk("t1_fill0", fill_level, 0);
    repeat (6) tick();
    chk("t1_done", bus.out_valid, 1'b0);
    chk("t1_q", q.size(), 0);

    // Stalled link: fill, then overflow on the extra sample
    bus.out_ready = 1'b0;
    for (int s = 1; s <= DEPTH + 2; s++) begin
      ri = 24'($urandom); rq = 24'($urandom);
      strobe(ri, rq, s <= DEPTH + 1);
      repeat (9) tick();
      if (s == DEPTH + 1) begin
        chk("t2_full", fill_level, DEPTH);
        chk("t2_noovf", overflow, 1'b0);
      end
    end
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_fill", fill_level, DEPTH);
    drain("t2", 400);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t2_clr", overflow, 1'b0);

    // Continuous stream, framing positions and no idle cycles
    do_reset();
    track = 1'b1;
    for (int s = 0; s < 64; s++) begin
      strobe(24'($urandom), 24'($urandom), 1'b1);
      repeat (5) tick();
    end
    drain("t3", 100);
    track = 1'b0;
    chk("t3_eof_pos", eof_pos, 378);
    chk("t3_sof_pos", sof2_pos, 379);
    chk("t3_idle", idle_cnt, 0);
    chk("t3_count", dcount, 384);

    // Random back-pressure
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (c % 14 == 0 && c < 280) begin
        strobe(24'($urandom), 24'($urandom), 1'b1);
      end else begin
        tick();
      end
    end
    drain("t4", 400);
    chk("t4_noovf", overflow, 1'b0);

    // Full FIFO: strobe coinciding with the byte-5 pop, then set/clear collision
    bus.out_ready = 1'b0;
    for (int s = 0; s < DEPTH + 1; s++) strobe(24'($urandom), 24'($urandom), 1'b1);
    chk("t5_full", fill_level, DEPTH);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    strobe(24'($urandom), 24'($urandom), 1'b1);
    bus.out_ready = 1'b0;
    chk("t5_noovf", overflow, 1'b0);
    chk("t5_fill", fill_level, DEPTH);
    clear_overflow = 1'b1;
    strobe(24'($urandom), 24'($urandom), 1'b0);
    clear_overflow = 1'b0;
    chk("t5_setwins", overflow, 1'b1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t5_clr", overflow, 1'b0);
    drain("t5", 400);

    // Reset in the middle of a sample
    bus.out_ready = 1'b1;
    strobe(24'($urandom), 24'($urandom), 1'b1);
    strobe(24'($urandom), 24'($urandom), 1'b1);
    repeat (3) tick();
    chk("t6_b3", bus.out_data, q[0]);
    do_reset();
    chk("t6_valid", bus.out_valid, 1'b0);
    chk("t6_fill", fill_level, 0);
    strobe(24'h800001, 24'h7FFFFE, 1'b1);
    tick();
    chk("t6_valid2", bus.out_valid, 1'b1);
    chk("t6_b0", bus.out_data, 8'h80);
    chk("t6_sof", bus.out_sof, 1'b1);
    drain("t6", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
